// File: rtl/l2_refill_responder.sv
// Responder for L1 I-cache block refills: one-block line buffer in front of a
// 32-bit word memory port, filled critical-word-first with pipelined reads.
module l2_refill_responder #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          WRAP_FIRST      = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         L2_read_en,
  input  logic [31:0]  L2_addr_read,
  output logic [255:0] L2_block_read,
  output logic         L2_stall,
  input  logic         flush,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ready,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata
);

  localparam int unsigned TAG_W   = 27;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned BLOCK_W = 256;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state, state_d;
  logic               buf_valid, buf_valid_d;
  logic [TAG_W-1:0]   buf_tag, buf_tag_d;
  logic [TAG_W-1:0]   fill_tag, fill_tag_d;
  logic [BLOCK_W-1:0] block_d;
  logic [BLOCK_W-1:0] asm_q, asm_d;
  logic [2:0]         start, start_d;
  logic [CNT_W-1:0]   issue_cnt, issue_d;
  logic [CNT_W-1:0]   ret_cnt, ret_d;
  logic [CNT_W-1:0]   outstanding_d;
  logic               flush_pend, flush_pend_d;
  logic               mem_req_d;
  logic [31:0]        mem_addr_d;
  logic               hit;
  logic               accept;
  logic               rvalid_ok;
  logic [2:0]         lane;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^L2_addr_read[1:0];

  assign hit      = buf_valid && (L2_addr_read[31:5] == buf_tag);
  assign L2_stall = L2_read_en && !(hit && (state == IDLE));

  // Next-state, fill bookkeeping and registered memory-port outputs
  always_comb begin
    state_d       = state;
    buf_valid_d   = buf_valid;
    buf_tag_d     = buf_tag;
    block_d       = L2_block_read;
    asm_d         = asm_q;
    fill_tag_d    = fill_tag;
    start_d       = start;
    issue_d       = issue_cnt;
    ret_d         = ret_cnt;
    flush_pend_d  = flush_pend;
    mem_req_d     = 1'b0;
    mem_addr_d    = mem_addr;
    outstanding_d = '0;
    accept        = mem_req && mem_ready;
    rvalid_ok     = mem_rvalid && (issue_cnt != ret_cnt);
    lane          = start + ret_cnt[2:0];

    unique case (state)
      IDLE: begin
        if (flush) buf_valid_d = 1'b0;
        if (L2_read_en && !hit) begin
          state_d      = FILL;
          fill_tag_d   = L2_addr_read[31:5];
          start_d      = WRAP_FIRST ? L2_addr_read[4:2] : 3'd0;
          issue_d      = '0;
          ret_d        = '0;
          flush_pend_d = 1'b0;
          mem_req_d    = 1'b1;
          mem_addr_d   = {L2_addr_read[31:5], start_d, 2'b00};
        end
      end
      FILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (accept) issue_d = issue_cnt + CNT_W'(1);
        if (rvalid_ok) begin
          asm_d[WORD_W*lane +: WORD_W] = mem_rdata;
          ret_d = ret_cnt + CNT_W'(1);
        end
        outstanding_d = issue_d - ret_d;
        // Last beat installs the assembled block; a late flush still wins
        if (rvalid_ok && (ret_cnt == CNT_W'(7))) begin
          state_d     = IDLE;
          block_d     = asm_d;
          buf_tag_d   = fill_tag;
          buf_valid_d = !(flush_pend || flush);
        end else if ((issue_d < CNT_W'(8)) && (outstanding_d < CNT_W'(MAX_OUTSTANDING))) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {fill_tag, 3'(start + issue_d[2:0]), 2'b00};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      buf_valid     <= 1'b0;
      buf_tag       <= '0;
      L2_block_read <= '0;
      asm_q         <= '0;
      fill_tag      <= '0;
      start         <= '0;
      issue_cnt     <= '0;
      ret_cnt       <= '0;
      flush_pend    <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
    end else begin
      state         <= state_d;
      buf_valid     <= buf_valid_d;
      buf_tag       <= buf_tag_d;
      L2_block_read <= block_d;
      asm_q         <= asm_d;
      fill_tag      <= fill_tag_d;
      start         <= start_d;
      issue_cnt     <= issue_d;
      ret_cnt       <= ret_d;
      flush_pend    <= flush_pend_d;
      mem_req       <= mem_req_d;
      mem_addr      <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_l2_refill_responder.sv
// Directed bench for l2_refill_responder with an in-order word memory model.
module tb_l2_refill_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         L2_read_en;
  logic [31:0]  L2_addr_read;
  logic [255:0] L2_block_read;
  logic         L2_stall;
  logic         flush;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  // memory model controls (written by the stimulus only)
  int          lat       = 1;
  bit          toggle    = 1'b0;
  logic [31:0] base      = 32'hA000_0000;
  int          clear_gen = 0;
  int          stray_req = 0;

  // memory model state (written by the model only)
  int          cyc        = 0;
  int          acc_cnt    = 0;
  int          rv_cnt     = 0;
  int          max_out    = 0;
  int          stable_err = 0;
  int          clear_seen = 0;
  int          stray_done = 0;
  bit          hold_chk   = 1'b0;
  bit          stray_on   = 1'b0;
  logic [31:0] held       = '0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] addr_log[$];

  l2_refill_responder #(.MAX_OUTSTANDING(2), .WRAP_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .L2_read_en   (L2_read_en),
    .L2_addr_read (L2_addr_read),
    .L2_block_read(L2_block_read),
    .L2_stall     (L2_stall),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory: records accepts at the edge, answers in order on the falling edge
  initial begin
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (hold_chk && !(mem_req && (mem_addr == held))) stable_err++;
        hold_chk = mem_req && !mem_ready;
        held     = mem_addr;
        if (mem_rvalid && !stray_on) rv_cnt++;
        if (mem_req && mem_ready) begin
          q_addr.push_back(mem_addr);
          q_due.push_back(cyc + lat);
          addr_log.push_back(mem_addr);
          acc_cnt++;
        end
        if (acc_cnt - rv_cnt > max_out) max_out = acc_cnt - rv_cnt;
      end else begin
        hold_chk = 1'b0;
      end
      cyc++;
      @(negedge clk);
      if (clear_gen != clear_seen) begin
        clear_seen = clear_gen;
        q_addr.delete();
        q_due.delete();
        addr_log.delete();
        acc_cnt    = 0;
        rv_cnt     = 0;
        max_out    = 0;
        stable_err = 0;
        hold_chk   = 1'b0;
      end
      mem_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      stray_on  = 1'b0;
      if (stray_done < stray_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        stray_on   = 1'b1;
        stray_done++;
      end else if ((q_due.size() > 0) && (q_due[0] <= cyc)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = base + 32'(q_addr[0][4:2]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] blk(input logic [31:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = b + 32'(i);
    return r;
  endfunction

  task automatic clear_mem(input logic [31:0] b, input int l, input bit t);
    @(negedge clk);
    base   = b;
    lat    = l;
    toggle = t;
    clear_gen++;
    repeat (2) @(negedge clk);
  endtask

  // Raise a request and count stalled cycles up to the grant
  task automatic req(input string tag, input logic [31:0] a, output int stalls);
    @(negedge clk);
    L2_read_en   = 1'b1;
    L2_addr_read = a;
    stalls       = 0;
    #1;
    while (L2_stall && (stalls < 300)) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check({tag, "_timeout"}, 256'(L2_stall), 256'(0));
  endtask

  task automatic release_req();
    @(negedge clk);
    L2_read_en = 1'b0;
  endtask

  task automatic check_addrs(input string tag, input logic [31:0] a);
    logic [2:0]  w;
    logic [31:0] got;
    check({tag, "_addr_count"}, 256'(addr_log.size()), 256'(8));
    for (int i = 0; i < 8; i++) begin
      w   = a[4:2] + 3'(i);
      got = (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF;
      check($sformatf("%s_addr%0d", tag, i), 256'(got), 256'({a[31:5], w, 2'b00}));
    end
  endtask

  task automatic wait_rv(input int n);
    int k;
    k = 0;
    while ((rv_cnt < n) && (k < 300)) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int st;
    int k;
    rst_n        = 1'b0;
    L2_read_en   = 1'b0;
    L2_addr_read = '0;
    flush        = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 256'(L2_stall), 256'(0));
    check("rst_mem_req", 256'(mem_req), 256'(0));
    check("rst_mem_addr", 256'(mem_addr), 256'(0));
    check("rst_block", L2_block_read, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // cold miss, zero-wait memory
    clear_mem(32'hA000_0000, 1, 1'b0);
    req("cold", 32'h0000_1040, st);
    check("cold_stall", 256'(st), 256'(10));
    check("cold_block", L2_block_read, blk(32'hA000_0000));
    check_addrs("cold", 32'h0000_1040);
    release_req();

    // hit on the freshly filled block
    @(negedge clk);
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h0000_1048;
    #1;
    check("hit_stall", 256'(L2_stall), 256'(0));
    check("hit_block", L2_block_read, blk(32'hA000_0000));
    @(negedge clk);
    L2_read_en = 1'b0;
    repeat (2) @(negedge clk);
    check("hit_no_mem", 256'(acc_cnt), 256'(8));

    // critical word in lane 7, wrap to lane 0
    clear_mem(32'hB000_0000, 1, 1'b0);
    req("wrap", 32'h0000_205C, st);
    check("wrap_stall", 256'(st), 256'(10));
    check("wrap_block", L2_block_read, blk(32'hB000_0000));
    check_addrs("wrap", 32'h0000_205C);
    release_req();

    // backpressure with 3-cycle latency
    clear_mem(32'hC000_0000, 3, 1'b1);
    req("bp", 32'h0000_3000, st);
    check("bp_block", L2_block_read, blk(32'hC000_0000));
    check("bp_max_out", 256'(max_out), 256'(2));
    check("bp_addr_stable", 256'(stable_err), 256'(0));
    check_addrs("bp", 32'h0000_3000);
    release_req();

    // abandon after 3 beats with a flush during the fill
    clear_mem(32'hD000_0000, 3, 1'b1);
    @(negedge clk);
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h0000_4000;
    wait_rv(3);
    L2_read_en = 1'b0;
    flush      = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    k = 0;
    while (((rv_cnt < 8) || mem_req) && (k < 300)) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("abandon_drain_rv", 256'(rv_cnt), 256'(8));
    check("abandon_drain_acc", 256'(acc_cnt), 256'(8));
    check("abandon_prefetch_data", L2_block_read, blk(32'hD000_0000));
    clear_mem(32'hE000_0000, 1, 1'b0);
    req("reflush", 32'h0000_4000, st);
    check("reflush_stall", 256'(st), 256'(10));
    check("reflush_block", L2_block_read, blk(32'hE000_0000));
    check("reflush_acc", 256'(acc_cnt), 256'(8));
    release_req();

    // async reset after 4 beats, then stray responses
    clear_mem(32'h1111_0000, 1, 1'b0);
    @(negedge clk);
    L2_read_en   = 1'b1;
    L2_addr_read = 32'h0000_5000;
    wait_rv(4);
    rst_n      = 1'b0;
    L2_read_en = 1'b0;
    #1;
    check("rst_mid_req", 256'(mem_req), 256'(0));
    check("rst_mid_block", L2_block_read, 256'(0));
    clear_mem(32'h1111_0000, 1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_req = stray_req + 2;
    repeat (4) @(negedge clk);
    check("stray_block", L2_block_read, 256'(0));
    check("stray_no_req", 256'(mem_req), 256'(0));
    clear_mem(32'h2222_0000, 1, 1'b0);
    req("after_rst", 32'h0000_5000, st);
    check("after_rst_stall", 256'(st), 256'(10));
    check("after_rst_block", L2_block_read, blk(32'h2222_0000));
    release_req();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/l2_refill_responder.md
Name: l2_refill_responder

Overview:
Responder end of the L1 instruction-cache refill port. It accepts block read requests (L2_read_en / L2_addr_read), holds L2_stall high until the 256-bit block is available, and returns it on L2_block_read. Misses are filled from a 32-bit word-wide memory port as eight pipelined single-word reads, issued critical-word-first. A one-block line buffer serves repeat requests with zero added latency.

Parameters:
MAX_OUTSTANDING, 4, maximum number of issued-but-unreturned memory reads (1..8).
WRAP_FIRST, 1, 1 = issue beats starting at L2_addr_read[4:2] and wrap modulo 8; 0 = always start at word 0.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
L2_read_en  in  1  refill request; held high with a stable address until granted
L2_addr_read  in  32  request address; bits [31:5] select the block
L2_block_read  out  256  block data; word i occupies bits [32i+31:32i]
L2_stall  out  1  high while a request is pending and not yet served
flush  in  1  invalidate the line buffer (fence.i)
mem_req  out  1  memory word read request
mem_addr  out  32  word address, 4-byte aligned
mem_ready  in  1  memory accepts the request this cycle (mem_req & mem_ready)
mem_rvalid  in  1  read data valid; responses return in issue order
mem_rdata  in  32  read data

Behaviour:
- Reset values: buf_valid=0, buf_tag=0, L2_block_read=0, mem_req=0, mem_addr=0, state=IDLE, all counters 0.
- Hit definition: hit = buf_valid & (L2_addr_read[31:5]==buf_tag).
- L2_stall is combinational: L2_stall = L2_read_en & ~(hit & state==IDLE). It is 0 whenever L2_read_en=0.
- L2_block_read always drives the buffer contents. A grant is any cycle with L2_read_en=1 and L2_stall=0.
- States:
  - IDLE:
    - L2_read_en & hit: grant in the same cycle, with 0 added latency.
    - L2_read_en & ~hit: latch fill_tag=addr[31:5] and start=addr[4:2] (0 when WRAP_FIRST=0), clear issue_cnt/ret_cnt, set flush_pend=0, then go to FILL.
  - FILL:
    - Issue: mem_req=1 while issue_cnt<8 and (issue_cnt-ret_cnt)<MAX_OUTSTANDING.
    - mem_addr = {fill_tag, (start+issue_cnt)[2:0], 2'b00}. The 3-bit word index wraps 7→0.
    - issue_cnt increments on mem_req&mem_ready.
    - Return: on mem_rvalid, write mem_rdata into word lane (start+ret_cnt)[2:0] of the assembly register, then increment ret_cnt.
    - mem_rvalid with zero outstanding reads is a protocol error and is ignored.
    - When ret_cnt reaches 8 (last beat): copy the assembly register to the buffer, set buf_tag=fill_tag, set buf_valid=~flush_pend, then go to IDLE.
    - A request still pending for fill_tag hits and is granted the cycle after the last beat.
- Miss latency: request seen in cycle 0; first mem_req in cycle 1; grant in the cycle after the 8th mem_rvalid. With a zero-wait memory that returns data the cycle after acceptance and MAX_OUTSTANDING>=2, grant is in cycle 10.
- Abandoned request (L2_read_en drops during FILL, e.g. mispredict): the fill completes and drains all outstanding reads. The block is still installed as a prefetch.
- New request during FILL with a different block: stalled until FILL ends, then re-evaluated in IDLE. It misses and starts a new fill the next cycle.
- flush:
  - In IDLE: clears buf_valid at the next edge. A same-cycle hit is still granted.
  - In FILL: sets flush_pend. The block is installed with buf_valid=0 and the requester re-misses.
- Async reset mid-FILL: the state returns to IDLE immediately and the buffer is invalid. Late mem_rvalid responses after reset are ignored (zero outstanding).
- At most one block fill is in flight. mem_req/mem_addr are registered outputs and are held stable while mem_ready=0.

Test Plan:
- Cold miss: addr 0x0000_1040, WRAP_FIRST=1, memory returns word index k as 0xA000_0000+k → mem_addr sequence 0x1040,44,48,4C,50,54,58,5C; grant with lane0=0xA000_0000 … lane7=0xA000_0007; L2_stall is 1 for exactly 10 cycles with zero-wait memory.
- Wrap order: addr 0x0000_205C → mem_addr 0x205C,0x2040,0x2044,…,0x2058; lane 7 gets the first returned beat.
- Hit: re-request 0x0000_1048 right after the cold-miss fill → L2_stall=0 in the same cycle as L2_read_en; no mem_req.
- Backpressure/outstanding: MAX_OUTSTANDING=2, mem_ready toggling 1/0, 3-cycle read latency → never more than 2 unreturned reads; block correct; mem_addr stable while mem_ready=0.
- Abandon + flush: drop L2_read_en after 3 beats and assert flush during FILL → all 8 reads still drain; a subsequent request for the same block misses and refills.
- Reset mid-fill: rst_n low after 4 beats, then 2 stray mem_rvalid pulses → no buffer write; a fresh request misses, refills cleanly, and returns correct data.
